// File: rtl/conv_output_compactor_pkg.sv
// Processing settings for the convolution datapath, including the partition
// tables, mode/stride types and FSM states of the output compactor.
package pkg_processing;

    // Convolution settings
    localparam int CONV_SIZE       = 31;
    localparam int CONV_BITS       = 8;
    localparam int CONV_PAR_MODES  = 3;
    localparam int CONV_PAR_MAX    = 6;
    localparam int CONV_STRIDE_MAX = 4;

    // Active partitions per parallel mode
    localparam int CONV_PAR_NUM [CONV_PAR_MODES] = '{1, 2, 6};

    // Inclusive {first, last} valid output lane per partition; unused slots are zero
    localparam int CONV_PAR_OUT [CONV_PAR_MODES][CONV_PAR_MAX][2] = '{
        '{'{0, 27}, '{0, 0},   '{0, 0},   '{0, 0},   '{0, 0},   '{0, 0}},
        '{'{0, 9},  '{14, 23}, '{0, 0},   '{0, 0},   '{0, 0},   '{0, 0}},
        '{'{0, 0},  '{6, 6},   '{12, 12}, '{18, 18}, '{24, 24}, '{30, 30}}
    };

    typedef logic [$clog2(CONV_PAR_MODES)-1:0]    mode_t;
    typedef logic [$clog2(CONV_STRIDE_MAX+1)-1:0] stride_t;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    // Zero stride behaves as one; anything above the maximum saturates.
    function automatic int clamp_stride(input int s, input int smax);
        if (s == 0) return 1;
        if (s > smax) return smax;
        return s;
    endfunction

endpackage

// File: rtl/conv_output_compactor_if.sv
// Row input and element output bundle of the convolution output compactor.
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both high; a source holds its payload stable while valid is high and ready
// is low, and valid never depends on ready.
interface conv_output_compactor_if #(
    parameter int SIZE       = 31,
    parameter int BITS       = 8,
    parameter int PAR_MODES  = 3,
    parameter int PAR_MAX    = 6,
    parameter int STRIDE_MAX = 4
);
    logic                                 row_valid;
    logic                                 row_ready;
    logic [SIZE-1:0][BITS-1:0]            row_data;
    logic [$clog2(PAR_MODES)-1:0]         cfg_mode;
    logic [$clog2(STRIDE_MAX+1)-1:0]      cfg_stride;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [BITS-1:0]                      out_data;
    logic [$clog2(PAR_MAX)-1:0]           out_part;
    logic [$clog2(SIZE)-1:0]              out_col;
    logic                                 out_last;
    logic                                 cfg_err;

    modport master (
        output row_valid, row_data, cfg_mode, cfg_stride, out_ready,
        input  row_ready, out_valid, out_data, out_part, out_col, out_last, cfg_err
    );

    modport slave (
        input  row_valid, row_data, cfg_mode, cfg_stride, out_ready,
        output row_ready, out_valid, out_data, out_part, out_col, out_last, cfg_err
    );
endinterface

// File: rtl/conv_output_compactor_lane_stepper.sv
// Walks the valid lanes of a captured row: tracks lane, column and partition
// counters and flags the final element of the row.
module conv_lane_stepper
    import pkg_processing::*;
#(
    parameter int SIZE       = CONV_SIZE,
    parameter int PAR_MODES  = CONV_PAR_MODES,
    parameter int PAR_MAX    = CONV_PAR_MAX,
    parameter int PAR_NUM [PAR_MODES] = CONV_PAR_NUM,
    parameter int PAR_OUT [PAR_MODES][PAR_MAX][2] = CONV_PAR_OUT,
    parameter int STRIDE_MAX = CONV_STRIDE_MAX,
    localparam int MODE_W    = $clog2(PAR_MODES),
    localparam int STRIDE_W  = $clog2(STRIDE_MAX + 1),
    localparam int PART_W    = $clog2(PAR_MAX),
    localparam int COL_W     = $clog2(SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [MODE_W-1:0]   load_mode,
    input  logic [MODE_W-1:0]   cur_mode,
    input  logic [STRIDE_W-1:0] stride,
    input  logic                advance,
    output logic [COL_W-1:0]    lane_idx,
    output logic [COL_W-1:0]    col,
    output logic [PART_W-1:0]   part,
    output logic                row_last
);
    // One extra bit so lane + stride past the row end compares correctly.
    localparam int LANE_W = COL_W + 1;

    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] lane_first;
    logic [LANE_W-1:0] next_lane;
    logic [LANE_W-1:0] last_lane;
    logic [LANE_W-1:0] next_first;
    logic              lane_last;

    // Partition bounds lookup and next-lane/last-element flags.
    always_comb begin
        int cm;
        int lm;
        int cp;
        int np;
        cm = (int'(cur_mode) < PAR_MODES) ? int'(cur_mode) : 0;
        lm = (int'(load_mode) < PAR_MODES) ? int'(load_mode) : 0;
        cp = (int'(part) < PAR_MAX) ? int'(part) : 0;
        np = (cp + 1 < PAR_MAX) ? cp + 1 : 0;
        lane_first = LANE_W'(PAR_OUT[lm][0][0]);
        last_lane  = LANE_W'(PAR_OUT[cm][cp][1]);
        next_first = LANE_W'(PAR_OUT[cm][np][0]);
        next_lane  = lane + LANE_W'(stride);
        lane_last  = next_lane > last_lane;
        row_last   = lane_last && (cp == PAR_NUM[cm] - 1);
    end

    // Counter update: a new row restarts at its first lane, otherwise step.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane <= '0;
            col  <= '0;
            part <= '0;
        end else if (load) begin
            lane <= lane_first;
            col  <= '0;
            part <= '0;
        end else if (advance) begin
            if (row_last) begin
                lane <= '0;
                col  <= '0;
                part <= '0;
            end else if (lane_last) begin
                lane <= next_first;
                col  <= '0;
                part <= part + 1'b1;
            end else begin
                lane <= next_lane;
                col  <= col + 1'b1;
            end
        end
    end

    assign lane_idx = lane[COL_W-1:0];

endmodule

// File: rtl/conv_output_compactor.sv
// Compacts a convolution output row into a stream of valid elements, one per
// cycle, walking each partition of the selected parallel mode with a stride.
module conv_output_compactor
    import pkg_processing::*;
#(
    parameter int SIZE       = CONV_SIZE,
    parameter int BITS       = CONV_BITS,
    parameter int PAR_MODES  = CONV_PAR_MODES,
    parameter int PAR_MAX    = CONV_PAR_MAX,
    parameter int PAR_NUM [PAR_MODES] = CONV_PAR_NUM,
    parameter int PAR_OUT [PAR_MODES][PAR_MAX][2] = CONV_PAR_OUT,
    parameter int STRIDE_MAX = CONV_STRIDE_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    conv_output_compactor_if.slave bus,
    output state_t                 dbg_state
);
    localparam int MODE_W   = $clog2(PAR_MODES);
    localparam int STRIDE_W = $clog2(STRIDE_MAX + 1);
    localparam int PART_W   = $clog2(PAR_MAX);
    localparam int COL_W    = $clog2(SIZE);

    // Every active partition range must lie inside the row.
    function automatic bit cfg_ok();
        for (int m = 0; m < PAR_MODES; m++) begin
            if (PAR_NUM[m] < 1 || PAR_NUM[m] > PAR_MAX) return 1'b0;
            for (int p = 0; p < PAR_MAX; p++) begin
                if (p < PAR_NUM[m] &&
                    (PAR_OUT[m][p][0] > PAR_OUT[m][p][1] || PAR_OUT[m][p][1] >= SIZE))
                    return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    localparam bit CFG_OK = cfg_ok();

    if (!CFG_OK) begin : g_bad_cfg
        $error("conv_output_compactor: PAR_NUM/PAR_OUT range outside the lane row");
    end

    state_t                    state_q, state_d;
    logic [SIZE-1:0][BITS-1:0] row_q;
    logic [MODE_W-1:0]         mode_q;
    logic [STRIDE_W-1:0]       stride_q;
    logic                      cfg_err_q, cfg_err_d;
    logic                      mode_legal;
    logic                      load, advance;
    logic                      row_ready, out_valid;
    logic [COL_W-1:0]          lane_idx, col;
    logic [PART_W-1:0]         part;
    logic                      row_last;

    assign mode_legal = int'(bus.cfg_mode) < PAR_MODES;
    assign advance    = out_valid && bus.out_ready;

    // Next state, row acceptance and illegal-mode detection.
    always_comb begin
        state_d   = state_q;
        row_ready = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        cfg_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                row_ready = 1'b1;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (bus.out_ready && row_last) begin
                    row_ready = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (row_ready && bus.row_valid) begin
            if (mode_legal) begin
                load    = 1'b1;
                state_d = ST_EMIT;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
        if (rst) row_ready = 1'b0;
    end

    // State register and capture of the accepted row and its configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cfg_err_q <= 1'b0;
            mode_q    <= '0;
            stride_q  <= STRIDE_W'(1);
        end else begin
            state_q   <= state_d;
            cfg_err_q <= cfg_err_d;
            if (load) begin
                mode_q   <= bus.cfg_mode;
                stride_q <= STRIDE_W'(clamp_stride(int'(bus.cfg_stride), STRIDE_MAX));
            end
        end
    end

    // Row payload holding register; no reset needed, it is only read in EMIT.
    always_ff @(posedge clk) begin
        if (load) row_q <= bus.row_data;
    end

    conv_lane_stepper #(
        .SIZE       (SIZE),
        .PAR_MODES  (PAR_MODES),
        .PAR_MAX    (PAR_MAX),
        .PAR_NUM    (PAR_NUM),
        .PAR_OUT    (PAR_OUT),
        .STRIDE_MAX (STRIDE_MAX)
    ) u_stepper (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_mode (bus.cfg_mode),
        .cur_mode  (mode_q),
        .stride    (stride_q),
        .advance   (advance),
        .lane_idx  (lane_idx),
        .col       (col),
        .part      (part),
        .row_last  (row_last)
    );

    assign bus.row_ready = row_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = row_q[lane_idx];
    assign bus.out_part  = part;
    assign bus.out_col   = col;
    assign bus.out_last  = out_valid && row_last;
    assign bus.cfg_err   = cfg_err_q;
    assign dbg_state     = state_q;

endmodule
